// File: rtl/ysyx_22050612_seq_ctrl.sv
// Multi-cycle instruction sequencer: fetch handshake, instruction hold, one-cycle
// writeback gate, PC ownership, retired-instruction count and halt detection.
module ysyx_22050612_seq_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        ex_done,
    input  logic [63:0] next_pc,
    input  logic        is_ebreak,
    output logic        wb_en,
    output logic [63:0] pc,
    output logic [63:0] instret,
    output logic        halted,
    output logic        bad_pc
);

    localparam logic [2:0] S_RST   = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_EXEC  = 3'd3;
    localparam logic [2:0] S_WB    = 3'd4;
    localparam logic [2:0] S_HALT  = 3'd5;

    logic [2:0]  state_q,   state_d;
    logic [63:0] pc_q,      pc_d;
    logic [63:0] pend_pc_q, pend_pc_d;
    logic [31:0] inst_q,    inst_d;
    logic [63:0] instret_q, instret_d;
    logic        bad_pc_q,  bad_pc_d;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        inst_d    = inst_q;
        instret_d = instret_q;
        bad_pc_d  = bad_pc_q;
        case (state_q)
            S_RST:   state_d = S_FETCH;
            S_FETCH: if (imem_ready) state_d = S_WAIT;
            S_WAIT: begin
                if (imem_rvalid) begin
                    inst_d  = imem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // ebreak retires without writeback and wins over the alignment check
                if (ex_done) begin
                    if (is_ebreak) begin
                        instret_d = instret_q + 64'd1;
                        state_d   = S_HALT;
                    end else if (next_pc[1:0] != 2'b00) begin
                        bad_pc_d = 1'b1;
                        state_d  = S_HALT;
                    end else begin
                        pend_pc_d = next_pc;
                        state_d   = S_WB;
                    end
                end
            end
            S_WB: begin
                pc_d      = pend_pc_q;
                instret_d = instret_q + 64'd1;
                state_d   = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RST;
            pc_q      <= RESET_PC;
            pend_pc_q <= RESET_PC;
            inst_q    <= 32'd0;
            instret_q <= 64'd0;
            bad_pc_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
            inst_q    <= inst_d;
            instret_q <= instret_d;
            bad_pc_q  <= bad_pc_d;
        end
    end

    // Moore outputs decoded from the registered state only
    assign imem_req   = (state_q == S_FETCH);
    assign imem_addr  = imem_req ? pc_q : 64'd0;
    assign inst_valid = (state_q == S_EXEC);
    assign wb_en      = (state_q == S_WB);
    assign halted     = (state_q == S_HALT);
    assign bad_pc     = bad_pc_q;
    assign inst       = inst_q;
    assign pc         = pc_q;
    assign instret    = instret_q;

endmodule

// File: doc/ysyx_22050612_seq_ctrl.md
# ysyx_22050612_seq_ctrl

Multi-cycle instruction sequencer for the single-issue RV64 core. It fetches from instruction memory over a request/response handshake and holds the fetched word stable for the decode unit and execute stage. It gates register-file writeback to one cycle per instruction, owns the PC register, counts retired instructions, and halts the core on `ebreak` or a misaligned next PC.

## Interface
Parameters:
- `RESET_PC`, default 64'h0000_0000_8000_0000: PC value loaded on reset.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req` out 1: fetch request, held until accepted.
- `imem_addr` out 64: fetch address; equals `pc` whenever `imem_req`=1.
- `imem_ready` in 1: memory accepts the request this cycle.
- `imem_rvalid` in 1: fetched word valid this cycle.
- `imem_rdata` in 32: fetched instruction word.
- `inst` out 32: latched instruction, driven to the decode unit.
- `inst_valid` out 1: high while `inst` is being executed (state EXEC).
- `ex_done` in 1: execute stage finished; `next_pc` valid this cycle.
- `next_pc` in 64: pc+4, branch target, or jump target from the execute stage.
- `is_ebreak` in 1: decode flag for inst 32'h00100073, sampled with `ex_done`.
- `wb_en` out 1: register-file write enable gate, one pulse per instruction.
- `pc` out 64: PC of the current instruction.
- `instret` out 64: retired-instruction count.
- `halted` out 1: core stopped.
- `bad_pc` out 1: the halt was caused by a misaligned `next_pc`.

## Operation
States are RST, FETCH, WAIT, EXEC, WB and HALT.

Reset (async, `rst_n`=0):
- state=RST, `pc`=RESET_PC, `inst`=0, `instret`=0.
- All single-bit outputs are 0.
- RST moves to FETCH unconditionally on the first clock edge after `rst_n` rises.

FETCH:
- `imem_req`=1 and `imem_addr`=`pc`.
- Moves to WAIT on `imem_req`&&`imem_ready`; otherwise stays with address stable.

WAIT:
- `imem_req`=0.
- On `imem_rvalid`: `inst`<=`imem_rdata` and move to EXEC.
- `imem_rvalid` is ignored in every other state.

EXEC:
- `inst_valid`=1 and `inst` is held constant.
- On `ex_done`:
  - `is_ebreak`=1: go to HALT; `pc` is unchanged, `instret` is incremented, no `wb_en` pulse.
  - `next_pc[1:0]`!=0: go to HALT with `bad_pc`<=1; `pc` and `instret` are unchanged.
  - Otherwise: latch `next_pc` into a pending register and go to WB.
- `is_ebreak` takes priority over the misaligned-PC check.

WB:
- `wb_en`=1 for exactly this one cycle.
- `pc`<=pending next PC and `instret`<=`instret`+1 (wraps modulo 2^64).
- Always moves to FETCH.

HALT:
- `halted`=1; all request and enable outputs are 0.
- HALT is absorbing; only reset leaves it.

## Timing
- Minimum instruction period is 4 cycles: FETCH (ready same cycle), WAIT (rvalid next cycle), EXEC (`ex_done` same cycle), WB.
- Each additional cycle of `imem_ready` low, `imem_rvalid` low, or `ex_done` low adds one cycle.
- `pc` updates on the edge that ends WB, so the new `pc` is visible in the FETCH cycle that follows.
- `wb_en`, `inst_valid` and `imem_req` are decoded from the registered state (Moore) with no combinational path from inputs.
- `halted` and `bad_pc` assert in the cycle after the EXEC cycle that samples `ex_done`.
- Reset mid-operation:
  - An outstanding fetch is abandoned; any late `imem_rvalid` arrives in RST or FETCH and is ignored.
  - `wb_en` drops immediately (asynchronously).
- `imem_ready` and `imem_rvalid` both high in FETCH: only `imem_ready` is used; `imem_rvalid` is ignored.

## Test plan
- Reset with RESET_PC=64'h80000000, memory always ready, rvalid 1 cycle later, `ex_done` in first EXEC cycle, `next_pc`=`pc`+4 -> `imem_addr` sequence 80000000, 80000004, 80000008 every 4 cycles; one `wb_en` pulse per instruction; `instret`=3 after the third WB.
- `imem_ready` held low 3 cycles, then rvalid delayed 2 cycles -> `imem_req` stays high with a stable address for 4 cycles; `inst` equals `imem_rdata` captured on the rvalid cycle; period is 8 cycles.
- Branch: `next_pc`=64'h80000100 with `ex_done` -> next `imem_addr`=80000100; stray rvalid pulses in EXEC leave `inst` unchanged.
- `ebreak` (rdata 32'h00100073, `is_ebreak`=1) -> `halted`=1, `bad_pc`=0, no `wb_en` pulse, `instret` incremented, `pc` frozen; no further `imem_req` for 20 cycles.
- `next_pc`=64'h80000006 -> `halted`=1 and `bad_pc`=1, `instret` unchanged; assert `rst_n`=0 mid-WAIT on a later run -> all outputs 0 immediately, `pc`=RESET_PC, fetch restarts 2 cycles after `rst_n` release.
